// File: rtl/spi_reg_responder.sv
// SPI mode-0 target exposing a small 8-bit register file to an external host.
// Frame: {rw, addr[6:0]} then one data byte, MSB first; all SPI pins are resynchronised to clk.
`timescale 1ns/1ps
module spi_reg_responder #(
    parameter int          NUM_REGS  = 4,
    parameter logic [7:0]  RESET_VAL = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [NUM_REGS*8-1:0] reg_q,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr
);

    localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_e;

    logic       sck_s1_q, sck_s2_q, sck_dly_q;
    logic       cs_s1_q, cs_s2_q, cs_dly_q;
    logic       mosi_s1_q, mosi_s2_q;

    state_e     state_q;
    logic [3:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       rw_q;
    logic [6:0] addr_q;
    logic [6:0] miso_sh_q;
    logic       miso_q;
    logic       wr_strobe_q;
    logic [6:0] wr_addr_q;
    logic [7:0] regs_q [NUM_REGS];

    logic       sck_rise, sck_fall, cs_fall;
    logic [7:0] shift_d;
    logic [7:0] rd_byte;
    logic       wr_in_range;

    // Synchronisers idle at sck=0 / cs_n=1 so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s1_q  <= 1'b0;
            sck_s2_q  <= 1'b0;
            sck_dly_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            cs_dly_q  <= 1'b1;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= sck;
            sck_s2_q  <= sck_s1_q;
            sck_dly_q <= sck_s2_q;
            cs_s1_q   <= cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_dly_q  <= cs_s2_q;
            mosi_s1_q <= mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sck_rise    = sck_s2_q & ~sck_dly_q;
    assign sck_fall    = ~sck_s2_q & sck_dly_q;
    assign cs_fall     = ~cs_s2_q & cs_dly_q;
    assign shift_d     = {shift_q, mosi_s2_q};
    assign wr_in_range = {1'b0, addr_q} < NUM_REGS_W;

    // Read mux is indexed by the address byte as it completes, so bit 7 can go out at load.
    always_comb begin
        rd_byte = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (shift_d[6:0] == 7'(i)) begin
                rd_byte = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 7'd0;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            miso_sh_q   <= 7'd0;
            miso_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            // NOTE: the register file is reset explicitly; user logic consumes reg_q right after reset.
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            if (!ena || cs_s2_q) begin
                state_q   <= IDLE;
                bit_cnt_q <= 4'd0;
                miso_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            state_q   <= CMD;
                            bit_cnt_q <= 4'd0;
                            shift_q   <= 7'd0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            shift_q   <= shift_d[6:0];
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                state_q <= DATA;
                                rw_q    <= shift_d[7];
                                addr_q  <= shift_d[6:0];
                                if (shift_d[7]) begin
                                    miso_q    <= rd_byte[7];
                                    miso_sh_q <= rd_byte[6:0];
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (sck_rise) begin
                            shift_q <= shift_d[6:0];
                            if (bit_cnt_q == 4'd15) begin
                                state_q <= DONE;
                                miso_q  <= 1'b0;
                                if (!rw_q && wr_in_range) begin
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= addr_q;
                                    for (int i = 0; i < NUM_REGS; i++) begin
                                        if (addr_q == 7'(i)) begin
                                            regs_q[i] <= shift_d;
                                        end
                                    end
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end else if (sck_fall && rw_q && bit_cnt_q > 4'd8) begin
                            // The fall right after the load keeps bit 7; shifting starts after the 9th rise.
                            miso_q    <= miso_sh_q[6];
                            miso_sh_q <= {miso_sh_q[5:0], 1'b0};
                        end
                    end
                    DONE: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[8*g +: 8] = regs_q[g];
    end

    assign miso      = miso_q & ena;
    assign miso_oe   = ena & ~cs_s2_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule
